idu_inst_queue: RTL and testbench

- Multi-entry instruction queue between fetch and the decode/rename front-end.
- Replaces the single-entry stalled-instruction register.
- Accepts up to FETCH_WIDTH instructions per cycle and presents up to DECODE_WIDTH instructions per cycle in program order to decode.
- Absorbs decode stalls (ROB full, no free physical register) and empties on branch-mispredict flush.

---
 rtl/idu_inst_queue.sv | 124 ++++++++++++
 tb/tb_idu_inst_queue.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_inst_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : idu_inst_queue
// Purpose  : Multi-lane circular instruction queue between fetch and decode.
// Revision : 1.0 - initial release
// ============================================================================
module idu_inst_queue #(
   parameter int FETCH_WIDTH     = 2,
   parameter int DECODE_WIDTH    = 1,
   parameter int DEPTH           = 8,
   parameter int INST_ADDR_WIDTH = 32,
   parameter int INST_WIDTH      = 32
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   flush,
   input  logic [FETCH_WIDTH-1:0]                 in_valid,
   input  logic [FETCH_WIDTH*INST_WIDTH-1:0]      in_inst,
   input  logic [INST_ADDR_WIDTH-1:0]             in_pc,
   output logic                                   in_ready,
   input  logic                                   stall,
   output logic [DECODE_WIDTH-1:0]                out_valid,
   output logic [DECODE_WIDTH*INST_WIDTH-1:0]     out_inst,
   output logic [DECODE_WIDTH*INST_ADDR_WIDTH-1:0] out_pc,
   output logic [$clog2(DEPTH+1)-1:0]             count,
   output logic                                   empty,
   output logic                                   full
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [INST_WIDTH-1:0]      inst_q [DEPTH];
   logic [INST_ADDR_WIDTH-1:0] pc_q   [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] w_n_enq;
   logic [CNT_W-1:0] w_n_deq;
   logic             w_lead_run;

   // Offsets never exceed DEPTH, so one conditional subtract is enough.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input int unsigned       k);
      int unsigned s;
      s = 32'(p) + k;
      if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
      return PTR_W'(s);
   endfunction

   assign in_ready = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
   assign count    = count_q;
   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));

   // Only the leading run of valid lanes is taken; a hole truncates the group.
   always_comb begin
      w_n_enq    = '0;
      w_lead_run = 1'b1;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         w_lead_run = w_lead_run & in_valid[i];
         if (w_lead_run) w_n_enq = w_n_enq + CNT_W'(1);
      end
      if (!in_ready || flush) w_n_enq = '0;
   end

   always_comb begin
      w_n_deq = '0;
      for (int j = 0; j < DECODE_WIDTH; j++) begin
         if (out_valid[j]) w_n_deq = w_n_deq + CNT_W'(1);
      end
      if (stall) w_n_deq = '0;
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         wr_ptr_d = ptr_add(wr_ptr_q, 32'(w_n_enq));
         rd_ptr_d = ptr_add(rd_ptr_q, 32'(w_n_deq));
         count_d  = count_q + w_n_enq - w_n_deq;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         if (k < 32'(w_n_enq)) begin
            inst_q[ptr_add(wr_ptr_q, 32'(k))] <= in_inst[k*INST_WIDTH +: INST_WIDTH];
            pc_q[ptr_add(wr_ptr_q, 32'(k))]   <= in_pc + INST_ADDR_WIDTH'(4 * k);
         end
      end
   end

   generate
      for (genvar j = 0; j < DECODE_WIDTH; j++) begin : g_out
         logic [PTR_W-1:0] w_rd_idx;
         assign w_rd_idx = ptr_add(rd_ptr_q, 32'(j));
         assign out_valid[j] = !flush && (count_q > CNT_W'(j));
         assign out_inst[j*INST_WIDTH +: INST_WIDTH]           = inst_q[w_rd_idx];
         assign out_pc[j*INST_ADDR_WIDTH +: INST_ADDR_WIDTH]   = pc_q[w_rd_idx];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_idu_inst_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_idu_inst_queue
// Purpose  : Scoreboard bench for idu_inst_queue (depth 8, depth 6, 2-wide decode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_idu_inst_queue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  in_valid = 2'b00;
   logic [63:0] in_inst = '0;
   logic [31:0] in_pc = '0;

   logic        a_rdy, a_emp, a_full;
   logic [0:0]  a_ov;
   logic [31:0] a_oi, a_op;
   logic [3:0]  a_cnt;

   logic        b_rdy, b_emp, b_full;
   logic [0:0]  b_ov;
   logic [31:0] b_oi, b_op;
   logic [2:0]  b_cnt;

   logic        c_rdy, c_emp, c_full;
   logic [1:0]  c_ov;
   logic [63:0] c_oi, c_op;
   logic [3:0]  c_cnt;

   idu_inst_queue #(.FETCH_WIDTH(2), .DECODE_WIDTH(1), .DEPTH(8)) u_a (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
      .in_pc(in_pc), .in_ready(a_rdy), .stall(stall), .out_valid(a_ov), .out_inst(a_oi),
      .out_pc(a_op), .count(a_cnt), .empty(a_emp), .full(a_full));

   idu_inst_queue #(.FETCH_WIDTH(2), .DECODE_WIDTH(1), .DEPTH(6)) u_b (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
      .in_pc(in_pc), .in_ready(b_rdy), .stall(stall), .out_valid(b_ov), .out_inst(b_oi),
      .out_pc(b_op), .count(b_cnt), .empty(b_emp), .full(b_full));

   idu_inst_queue #(.FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(8)) u_c (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
      .in_pc(in_pc), .in_ready(c_rdy), .stall(stall), .out_valid(c_ov), .out_inst(c_oi),
      .out_pc(c_op), .count(c_cnt), .empty(c_emp), .full(c_full));

   int passed = 0;
   int total  = 0;

   // Selected instance and its reference model state.
   int          sel = 0;
   int          depth = 8;
   int          width = 1;
   int          mcount = 0;
   logic [31:0] next_pc = 32'h100;
   logic [31:0] q_pc[$];
   logic [31:0] q_inst[$];
   logic [31:0] last_pc = '0;
   int          n_popped = 0;

   logic [1:0]  s_ov;
   logic [31:0] s_pc0, s_pc1, s_in0, s_in1;
   int          s_cnt;
   logic        s_rdy;

   always_comb begin
      s_ov  = {1'b0, a_ov};
      s_pc0 = a_op;
      s_pc1 = '0;
      s_in0 = a_oi;
      s_in1 = '0;
      s_cnt = 32'(a_cnt);
      s_rdy = a_rdy;
      case (sel)
         1: begin
            s_ov = {1'b0, b_ov}; s_pc0 = b_op; s_in0 = b_oi;
            s_cnt = 32'(b_cnt); s_rdy = b_rdy;
         end
         2: begin
            s_ov = c_ov; s_pc0 = c_op[31:0]; s_pc1 = c_op[63:32];
            s_in0 = c_oi[31:0]; s_in1 = c_oi[63:32];
            s_cnt = 32'(c_cnt); s_rdy = c_rdy;
         end
         default: ;
      endcase
   end

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc * 32'd3 + 32'h1357_0000;
   endfunction

   // Structural invariants on every instance, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         total++;
         if (a_cnt <= 4'd8 && !(a_full && a_emp) &&
             ((32'(u_a.wr_ptr_q) + 8 - 32'(u_a.rd_ptr_q)) % 8) == (32'(a_cnt) % 8)) passed++;
         else $display("FAIL inv_a: cnt=%0d wr=%0d rd=%0d full=%b empty=%b",
                       a_cnt, u_a.wr_ptr_q, u_a.rd_ptr_q, a_full, a_emp);
         total++;
         if (b_cnt <= 3'd6 && !(b_full && b_emp) &&
             ((32'(u_b.wr_ptr_q) + 6 - 32'(u_b.rd_ptr_q)) % 6) == (32'(b_cnt) % 6)) passed++;
         else $display("FAIL inv_b: cnt=%0d wr=%0d rd=%0d full=%b empty=%b",
                       b_cnt, u_b.wr_ptr_q, u_b.rd_ptr_q, b_full, b_emp);
         total++;
         if (c_cnt <= 4'd8 && !(c_full && c_emp) &&
             ((32'(u_c.wr_ptr_q) + 8 - 32'(u_c.rd_ptr_q)) % 8) == (32'(c_cnt) % 8)) passed++;
         else $display("FAIL inv_c: cnt=%0d wr=%0d rd=%0d full=%b empty=%b",
                       c_cnt, u_c.wr_ptr_q, u_c.rd_ptr_q, c_full, c_emp);
      end
   end

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         reset = 1'b0; in_valid = 2'b00; stall = 1'b0; flush = 1'b0;
      end
      q_pc.delete(); q_inst.delete();
      mcount = 0; n_popped = 0;
   endtask

   // One cycle of stimulus: drive, compare against the model, pop/push scoreboard.
   task automatic cycle(input logic [1:0] v, input logic st, input logic fl);
      int          exp_n, nenq, ndeq;
      logic [1:0]  exp_ov;
      logic        exp_rdy;
      logic [31:0] pa, ia, ep, ei;
      @(posedge clk); #1;
      reset = 1'b1; in_valid = v; stall = st; flush = fl; in_pc = next_pc;
      in_inst = {inst_of(next_pc + 32'd4), inst_of(next_pc)};
      #2;
      exp_n   = fl ? 0 : ((mcount < width) ? mcount : width);
      exp_ov  = (exp_n == 0) ? 2'b00 : ((exp_n == 1) ? 2'b01 : 2'b11);
      exp_rdy = (depth - mcount) >= 2;
      total++;
      if (s_ov !== exp_ov) $display("FAIL out_valid: got %b expected %b", s_ov, exp_ov);
      else passed++;
      total++;
      if (s_cnt != mcount) $display("FAIL count: got %0d expected %0d", s_cnt, mcount);
      else passed++;
      total++;
      if (s_rdy !== exp_rdy) $display("FAIL in_ready: got %b expected %b", s_rdy, exp_rdy);
      else passed++;
      ndeq = st ? 0 : exp_n;
      for (int j = 0; j < ndeq; j++) begin
         pa = (j == 0) ? s_pc0 : s_pc1;
         ia = (j == 0) ? s_in0 : s_in1;
         total++;
         if (q_pc.size() == 0) begin
            $display("FAIL sb_underflow: lane %0d got pc %h with empty scoreboard", j, pa);
         end else begin
            passed++;
            ep = q_pc.pop_front();
            ei = q_inst.pop_front();
            total++;
            if (pa !== ep) $display("FAIL out_pc lane%0d: got %h expected %h", j, pa, ep);
            else passed++;
            total++;
            if (ia !== ei) $display("FAIL out_inst lane%0d: got %h expected %h", j, ia, ei);
            else passed++;
            if (n_popped > 0) begin
               total++;
               if (pa !== last_pc + 32'd4)
                  $display("FAIL pc_seq: got %h expected %h", pa, last_pc + 32'd4);
               else passed++;
            end
            last_pc = pa;
            n_popped++;
         end
      end
      if (fl) begin
         q_pc.delete(); q_inst.delete();
         mcount = 0; n_popped = 0;
      end else begin
         nenq = 0;
         if (exp_rdy) nenq = v[0] ? (v[1] ? 2 : 1) : 0;
         for (int k = 0; k < nenq; k++) begin
            q_pc.push_back(next_pc + 32'(4 * k));
            q_inst.push_back(inst_of(next_pc + 32'(4 * k)));
         end
         next_pc = next_pc + 32'(4 * nenq);
         mcount  = mcount + nenq - ndeq;
      end
   endtask

   task automatic select(input int s, input int d, input int w);
      sel = s; depth = d; width = w;
   endtask

   task automatic test_reset;
      select(0, 8, 1);
      do_reset(2);
      cycle(2'b00, 1'b1, 1'b0);
      total++;
      if (a_ov !== 1'b0 || a_emp !== 1'b1 || a_full !== 1'b0 || a_rdy !== 1'b1 || a_cnt !== 4'd0)
         $display("FAIL reset_state: got ov=%b empty=%b full=%b rdy=%b cnt=%0d expected 0 1 0 1 0",
                  a_ov, a_emp, a_full, a_rdy, a_cnt);
      else passed++;
   endtask

   task automatic test_basic_flow;
      select(0, 8, 1);
      next_pc = 32'h100;
      cycle(2'b11, 1'b0, 1'b0);
      cycle(2'b00, 1'b0, 1'b0);
      total++;
      if (a_op !== 32'h100 || a_oi !== inst_of(32'h100))
         $display("FAIL basic_A: got pc %h inst %h expected pc 100 inst %h", a_op, a_oi, inst_of(32'h100));
      else passed++;
      cycle(2'b00, 1'b0, 1'b0);
      total++;
      if (a_op !== 32'h104) $display("FAIL basic_B: got pc %h expected 104", a_op);
      else passed++;
      cycle(2'b00, 1'b0, 1'b0);
      total++;
      if (a_emp !== 1'b1 || a_cnt !== 4'd0)
         $display("FAIL basic_drained: got empty=%b cnt=%0d expected 1 0", a_emp, a_cnt);
      else passed++;
   endtask

   task automatic test_stall_full;
      select(0, 8, 1);
      do_reset(1);
      for (int i = 0; i < 4; i++) cycle(2'b11, 1'b1, 1'b0);
      cycle(2'b11, 1'b1, 1'b0);
      total++;
      if (a_cnt !== 4'd8 || a_full !== 1'b1 || a_rdy !== 1'b0)
         $display("FAIL full_state: got cnt=%0d full=%b rdy=%b expected 8 1 0", a_cnt, a_full, a_rdy);
      else passed++;
      cycle(2'b00, 1'b1, 1'b0);
      total++;
      if (a_cnt !== 4'd8) $display("FAIL fifth_dropped: got cnt=%0d expected 8", a_cnt);
      else passed++;
      for (int i = 0; i < 8; i++) cycle(2'b00, 1'b0, 1'b0);
      cycle(2'b00, 1'b0, 1'b0);
      total++;
      if (a_emp !== 1'b1 || n_popped != 8)
         $display("FAIL full_drain: got empty=%b popped=%0d expected 1 8", a_emp, n_popped);
      else passed++;
   endtask

   task automatic test_wrap;
      select(1, 6, 1);
      do_reset(1);
      for (int i = 0; i < 40; i++) cycle(2'b11, ((i % 3) == 1) ? 1'b1 : 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(2'b00, 1'b0, 1'b0);
      total++;
      if (b_emp !== 1'b1 || n_popped < 12)
         $display("FAIL wrap_drain: got empty=%b popped=%0d expected 1 >=12", b_emp, n_popped);
      else passed++;
   endtask

   task automatic test_noncontig;
      select(0, 8, 1);
      do_reset(1);
      cycle(2'b10, 1'b1, 1'b0);
      cycle(2'b00, 1'b1, 1'b0);
      total++;
      if (a_cnt !== 4'd0) $display("FAIL mask_10: got cnt=%0d expected 0", a_cnt);
      else passed++;
      cycle(2'b01, 1'b1, 1'b0);
      cycle(2'b00, 1'b1, 1'b0);
      total++;
      if (a_cnt !== 4'd1) $display("FAIL mask_01: got cnt=%0d expected 1", a_cnt);
      else passed++;
      cycle(2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_flush;
      select(0, 8, 1);
      do_reset(1);
      cycle(2'b11, 1'b1, 1'b0);
      cycle(2'b11, 1'b1, 1'b0);
      cycle(2'b01, 1'b1, 1'b0);
      cycle(2'b00, 1'b1, 1'b0);
      total++;
      if (a_cnt !== 4'd5) $display("FAIL flush_pre: got cnt=%0d expected 5", a_cnt);
      else passed++;
      cycle(2'b11, 1'b0, 1'b1);
      total++;
      if (a_ov !== 1'b0) $display("FAIL flush_valid: got %b expected 0", a_ov);
      else passed++;
      cycle(2'b00, 1'b1, 1'b0);
      total++;
      if (a_cnt !== 4'd0 || a_emp !== 1'b1)
         $display("FAIL flush_post: got cnt=%0d empty=%b expected 0 1", a_cnt, a_emp);
      else passed++;
      cycle(2'b11, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midop_dual;
      select(2, 8, 2);
      do_reset(1);
      cycle(2'b11, 1'b1, 1'b0);
      cycle(2'b01, 1'b1, 1'b0);
      cycle(2'b00, 1'b1, 1'b0);
      total++;
      if (c_cnt !== 4'd3) $display("FAIL mid_pre: got cnt=%0d expected 3", c_cnt);
      else passed++;
      do_reset(1);
      cycle(2'b00, 1'b1, 1'b0);
      total++;
      if (c_cnt !== 4'd0 || c_ov !== 2'b00)
         $display("FAIL mid_reset: got cnt=%0d ov=%b expected 0 00", c_cnt, c_ov);
      else passed++;
      cycle(2'b11, 1'b0, 1'b0);
      cycle(2'b01, 1'b0, 1'b0);
      total++;
      if (c_ov !== 2'b11) $display("FAIL dual_11: got %b expected 11", c_ov);
      else passed++;
      cycle(2'b00, 1'b0, 1'b0);
      total++;
      if (c_ov !== 2'b01) $display("FAIL dual_01: got %b expected 01", c_ov);
      else passed++;
      cycle(2'b00, 1'b0, 1'b0);
      total++;
      if (c_emp !== 1'b1) $display("FAIL dual_drain: got empty=%b expected 1", c_emp);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic_flow();
      test_stall_full();
      test_wrap();
      test_noncontig();
      test_flush();
      test_reset_midop_dual();
      @(posedge clk); #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
